// File: rtl/iter_shift_unit.sv
// iter_shift_unit: multi-cycle shift/rotate unit for the execute stage.
// The operand is shifted at most STEP bits per clock under a Start/Busy/Done
// handshake; the immediate is returned zero- and sign-extended alongside.
// Optional feature macro: SHIFT_ROTATE_EN. When it is defined, Mode 011/100
// rotate left/right; when it is undefined they pass the operand through and
// no rotate datapath exists.
module iter_shift_unit #(
    parameter int WIDTH = 16,
    parameter int STEP  = 4,
    parameter int AMT_W = 8,
    parameter int IMM_W = 12
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       Mode,
    input  logic [WIDTH-1:0] ShifterIn,
    input  logic [AMT_W-1:0] Amount,
    input  logic [IMM_W-1:0] ImmIn,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ShifterOut,
    output logic [WIDTH-1:0] ZeroExtOut,
    output logic [WIDTH-1:0] SignExtOut
);

    // Remaining counter must hold the value WIDTH itself (saturated shifts).
    localparam int CNT_W = $clog2(WIDTH + 1);
    // Amount comparison width: wide enough for both Amount and WIDTH.
    localparam int CMP_W = (AMT_W > 32) ? AMT_W : 32;

    localparam logic [CNT_W-1:0] WIDTH_C   = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] STEP_C    = CNT_W'(STEP);
    localparam logic [CMP_W-1:0] WIDTH_CMP = CMP_W'(WIDTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [2:0] MODE_SLL = 3'b000;
    localparam logic [2:0] MODE_SRL = 3'b001;
    localparam logic [2:0] MODE_SRA = 3'b010;
`ifdef SHIFT_ROTATE_EN
    localparam logic [2:0] MODE_ROL = 3'b011;
    localparam logic [2:0] MODE_ROR = 3'b100;
`endif

    logic [1:0]       state;
    logic [2:0]       modeReg;
    logic [WIDTH-1:0] workReg;
    logic [CNT_W-1:0] remaining;

    logic [CMP_W-1:0] amtWide;
    logic [CNT_W-1:0] effAmt;
    logic [CNT_W-1:0] stepAmt;
    logic [WIDTH-1:0] shiftNext;

    assign amtWide = CMP_W'(Amount);

    // Effective amount for the incoming request: saturate shifts, wrap rotates.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        effAmt = '0;
        case (Mode)
            MODE_SLL, MODE_SRL, MODE_SRA:
                effAmt = (amtWide >= WIDTH_CMP) ? WIDTH_C : CNT_W'(amtWide);
`ifdef SHIFT_ROTATE_EN
            MODE_ROL, MODE_ROR:
                effAmt = CNT_W'(amtWide % WIDTH_CMP);
`endif
            default:
                effAmt = '0;
        endcase
    end

    // Bits moved this clock: the remainder, capped at STEP.
    always_comb begin
        stepAmt = (remaining < STEP_C) ? remaining : STEP_C;
    end

    // One partial shift of the working register by stepAmt.
    always_comb begin
        shiftNext = workReg;
        case (modeReg)
            MODE_SLL: shiftNext = workReg << stepAmt;
            MODE_SRL: shiftNext = workReg >> stepAmt;
            // The MSB never changes during SRA, so the current MSB is the
            // original sign bit at every step.
            MODE_SRA: shiftNext = $unsigned($signed(workReg) >>> stepAmt);
`ifdef SHIFT_ROTATE_EN
            // stepAmt < WIDTH here because rotate amounts are reduced mod WIDTH.
            MODE_ROL: shiftNext = (workReg << stepAmt) | (workReg >> (WIDTH_C - stepAmt));
            MODE_ROR: shiftNext = (workReg >> stepAmt) | (workReg << (WIDTH_C - stepAmt));
`endif
            default:  shiftNext = workReg;
        endcase
    end

    // Control FSM plus working, counter and extension registers.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (Reset) begin
            state      <= S_IDLE;
            modeReg    <= '0;
            workReg    <= '0;
            remaining  <= '0;
            ZeroExtOut <= '0;
            SignExtOut <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (Start) begin
                        workReg    <= ShifterIn;
                        modeReg    <= Mode;
                        remaining  <= effAmt;
                        ZeroExtOut <= WIDTH'(ImmIn);
                        SignExtOut <= WIDTH'($signed(ImmIn));
                        state      <= (effAmt == '0) ? S_DONE : S_SHIFT;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    workReg   <= shiftNext;
                    remaining <= remaining - stepAmt;
                    if (remaining == stepAmt) begin
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign Busy       = (state == S_SHIFT);
    assign Done       = (state == S_DONE);
    assign ShifterOut = workReg;

endmodule

// File: tb/tb_iter_shift_unit.sv
// tb_iter_shift_unit: scoreboard bench for iter_shift_unit (WIDTH=16, STEP=4,
// AMT_W=8, IMM_W=12). Expectations are queued when a request is accepted and
// compared when Done is seen. Rotate expectations follow SHIFT_ROTATE_EN.
module tb_iter_shift_unit;

    localparam logic [2:0] SLL = 3'b000;
    localparam logic [2:0] SRL = 3'b001;
    localparam logic [2:0] SRA = 3'b010;
    localparam logic [2:0] ROL = 3'b011;
    localparam logic [2:0] ROR = 3'b100;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        Start;
    logic [2:0]  Mode;
    logic [15:0] ShifterIn;
    logic [7:0]  Amount;
    logic [11:0] ImmIn;
    logic        Busy;
    logic        Done;
    logic [15:0] ShifterOut;
    logic [15:0] ZeroExtOut;
    logic [15:0] SignExtOut;

    iter_shift_unit #(.WIDTH(16), .STEP(4), .AMT_W(8), .IMM_W(12)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .Start      (Start),
        .Mode       (Mode),
        .ShifterIn  (ShifterIn),
        .Amount     (Amount),
        .ImmIn      (ImmIn),
        .Busy       (Busy),
        .Done       (Done),
        .ShifterOut (ShifterOut),
        .ZeroExtOut (ZeroExtOut),
        .SignExtOut (SignExtOut)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       tag;
        logic [15:0] out;
        int          lat;
        logic [15:0] zext;
        logic [15:0] sext;
        int          acceptCycle;
        int          busyMark;
    } expEntry_t;

    expEntry_t sb[$];
    expEntry_t mon;

    int numChecks = 0;
    int numFails  = 0;
    int cycle     = 0;
    int busyTotal = 0;
    int doneCount = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        numChecks++;
        if (got !== exp) begin
            numFails++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference effective amount for the 16-bit configuration.
    function automatic int refEff(input logic [2:0] m, input logic [7:0] a);
        case (m)
            SLL, SRL, SRA: return (a > 8'd16) ? 16 : int'(a);
`ifdef SHIFT_ROTATE_EN
            ROL, ROR:      return int'(a) % 16;
`endif
            default:       return 0;
        endcase
    endfunction

    // Reference result, built one bit position at a time.
    function automatic logic [15:0] refResult(input logic [2:0] m, input logic [15:0] d,
                                              input logic [7:0] a);
        logic [15:0] r;
        int          e;
        r = d;
        e = refEff(m, a);
        for (int i = 0; i < e; i++) begin
            case (m)
                SLL:     r = {r[14:0], 1'b0};
                SRL:     r = {1'b0, r[15:1]};
                SRA:     r = {r[15], r[15:1]};
                ROL:     r = {r[14:0], r[15]};
                ROR:     r = {r[0], r[15:1]};
                default: r = r;
            endcase
        end
        return r;
    endfunction

    always @(posedge CLK) cycle <= cycle + 1;

    // Monitor: count Busy cycles and score each Done pulse against the queue.
    always @(negedge CLK) begin
        if (Busy === 1'b1) busyTotal++;
        if (Done === 1'b1) begin
            doneCount++;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(Done), 32'd0);
            end else begin
                mon = sb.pop_front();
                check({mon.tag, "_out"}, 32'(ShifterOut), 32'(mon.out));
                // The accepting edge counts as the first edge of the latency.
                check({mon.tag, "_lat"}, 32'(cycle - mon.acceptCycle + 1), 32'(mon.lat));
                check({mon.tag, "_busy"}, 32'(busyTotal - mon.busyMark), 32'(mon.lat - 1));
                check({mon.tag, "_zext"}, 32'(ZeroExtOut), 32'(mon.zext));
                check({mon.tag, "_sext"}, 32'(SignExtOut), 32'(mon.sext));
            end
        end
    end

    // Drive a request (called at a negedge) and queue its expectation at accept.
    task automatic issue(input string tag, input logic [2:0] m, input logic [15:0] d,
                         input logic [7:0] a, input logic [11:0] imm,
                         input logic [15:0] expOut, input int expLat, input bit track);
        expEntry_t e;
        Mode      = m;
        ShifterIn = d;
        Amount    = a;
        ImmIn     = imm;
        Start     = 1'b1;
        @(posedge CLK);
        #1;
        Start = 1'b0;
        if (track) begin
            e.tag         = tag;
            e.out         = expOut;
            e.lat         = expLat;
            e.zext        = {4'h0, imm};
            e.sext        = {{4{imm[11]}}, imm};
            e.acceptCycle = cycle;
            e.busyMark    = busyTotal;
            sb.push_back(e);
        end
    endtask

    // Return at the negedge where Done is high, or report a timeout.
    task automatic waitDone(input string tag);
        int n;
        n = 0;
        @(negedge CLK);
        while (Done !== 1'b1 && n < 40) begin
            @(negedge CLK);
            n++;
        end
        if (Done !== 1'b1) check({tag, "_timeout"}, 32'(Done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  rm;
        logic [15:0] rd;
        logic [7:0]  ra;
        logic [11:0] ri;
        int          re;
        int          doneMark;

        Reset     = 1'b1;
        Start     = 1'b0;
        Mode      = '0;
        ShifterIn = '0;
        Amount    = '0;
        ImmIn     = '0;
        repeat (3) @(negedge CLK);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_out",  32'(ShifterOut), 32'd0);
        check("rst_zext", 32'(ZeroExtOut), 32'd0);
        check("rst_sext", 32'(SignExtOut), 32'd0);
        Reset = 1'b0;
        @(negedge CLK);

        // Directed operations; each issue after waitDone is accepted in the Done cycle.
        issue("sll3", SLL, 16'hFFFF, 8'd3, 12'h800, 16'hFFF8, 2, 1'b1);
        waitDone("sll3");
        @(negedge CLK);
        issue("sll0", SLL, 16'hFFFF, 8'd0, 12'h7FF, 16'hFFFF, 1, 1'b1);
        check("sll0_nobusy", 32'(Busy), 32'd0);
        waitDone("sll0");
        issue("sra15", SRA, 16'h8000, 8'd15, 12'h123, 16'hFFFF, 5, 1'b1);
        waitDone("sra15");
        issue("srl20", SRL, 16'hFFFF, 8'd20, 12'hFFF, 16'h0000, 5, 1'b1);
        waitDone("srl20");
`ifdef SHIFT_ROTATE_EN
        issue("ror20", ROR, 16'h1234, 8'd20, 12'h055, 16'h4123, 2, 1'b1);
        waitDone("ror20");
        issue("rol1", ROL, 16'h8001, 8'd1, 12'hA00, 16'h0003, 2, 1'b1);
        waitDone("rol1");
`else
        issue("ror20", ROR, 16'h1234, 8'd20, 12'h055, 16'h1234, 1, 1'b1);
        waitDone("ror20");
        issue("rol1", ROL, 16'h8001, 8'd1, 12'hA00, 16'h8001, 1, 1'b1);
        waitDone("rol1");
`endif
        @(negedge CLK);

        // Start while Busy is ignored; changed inputs must not be sampled.
        issue("srl12", SRL, 16'hF000, 8'd12, 12'h9AB, 16'h000F, 4, 1'b1);
        @(negedge CLK);
        Mode      = SLL;
        Amount    = 8'd1;
        ShifterIn = 16'h1234;
        ImmIn     = 12'h111;
        Start     = 1'b1;
        check("ignored_busy", 32'(Busy), 32'd1);
        @(negedge CLK);
        Start = 1'b0;
        waitDone("srl12");

        // Start held in the Done cycle: accepted at that edge with no bubble.
        issue("b2b", SLL, 16'h0001, 8'd5, 12'h321, 16'h0020, 3, 1'b1);
        check("b2b_busy", 32'(Busy), 32'd1);
        waitDone("b2b");
        @(negedge CLK);

        // Random requests scored against the bitwise reference model.
        for (int i = 0; i < 12; i++) begin
            rm = 3'($urandom_range(0, 7));
            rd = 16'($urandom);
            ra = 8'($urandom_range(0, 40));
            ri = 12'($urandom);
            re = refEff(rm, ra);
            issue("rnd", rm, rd, ra, ri, refResult(rm, rd, ra), 1 + (re + 3) / 4, 1'b1);
            waitDone("rnd");
            if (i % 2 == 1) @(negedge CLK);
        end
        @(negedge CLK);

        // Reset in the second SHIFT cycle of a by-15 operation.
        issue("rst15", SLL, 16'hFFFF, 8'd15, 12'hABC, 16'h0000, 5, 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        check("rst_mid_busy", 32'(Busy), 32'd1);
        Reset = 1'b1;
        @(negedge CLK);
        check("rst_mid_busy_clr", 32'(Busy), 32'd0);
        check("rst_mid_done",     32'(Done), 32'd0);
        check("rst_mid_out",      32'(ShifterOut), 32'd0);
        check("rst_mid_zext",     32'(ZeroExtOut), 32'd0);
        check("rst_mid_sext",     32'(SignExtOut), 32'd0);
        Reset    = 1'b0;
        doneMark = doneCount;
        repeat (10) @(negedge CLK);
        check("rst_no_done", 32'(doneCount - doneMark), 32'd0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", numChecks, numFails);
        $finish;
    end

endmodule
